// File: rtl/click_classifier.sv
// click_classifier: groups debounced press pulses into 1..MAX_CLICKS gestures
// and hands each gesture to a consumer as a single valid/ready event.
module click_classifier #(
  parameter int WINDOW_CYCLES = 25_000_000,
  parameter int MAX_CLICKS    = 3,
  parameter int CW            = $clog2(MAX_CLICKS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          press_edge,
  output logic          evt_valid,
  output logic [CW-1:0] evt_count,
  input  logic          evt_ready,
  output logic          busy,
  output logic          overflow
);

  // A one-cycle window would give a zero-width timer; keep at least one bit.
  localparam int            TW     = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(MAX_CLICKS);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clicks_q, clicks_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          emit;
  logic [CW-1:0] emit_n;

  // Gesture state registers; reset discards any gesture in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      clicks_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      clicks_q <= clicks_d;
      timer_q  <= timer_d;
    end
  end

  // Next-state: count clicks, restart the idle window on each press, and
  // close the gesture on reaching MAX_CLICKS or on window expiry. A press on
  // the expiry cycle takes priority and extends the gesture.
  always_comb begin
    state_d  = state_q;
    clicks_d = clicks_q;
    timer_d  = timer_q;
    emit     = 1'b0;
    emit_n   = '0;
    case (state_q)
      IDLE: begin
        if (press_edge) begin
          state_d  = COLLECT;
          clicks_d = CW'(1);
          timer_d  = '0;
        end
      end
      COLLECT: begin
        if (press_edge) begin
          if (clicks_q + 1'b1 == C_MAX) begin
            emit     = 1'b1;
            emit_n   = C_MAX;
            state_d  = IDLE;
            clicks_d = '0;
            timer_d  = '0;
          end else begin
            clicks_d = clicks_q + 1'b1;
            timer_d  = '0;
          end
        end else if (timer_q == T_LAST) begin
          emit     = 1'b1;
          emit_n   = clicks_q;
          state_d  = IDLE;
          clicks_d = '0;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        clicks_d = '0;
        timer_d  = '0;
      end
    endcase
  end

  // Single-entry event holding register. A new gesture may replace an event
  // being accepted this cycle; otherwise it is dropped while one is pending
  // and the sticky overflow flag records the loss.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else if (emit) begin
      if (!evt_valid || evt_ready) begin
        evt_valid <= 1'b1;
        evt_count <= emit_n;
      end else begin
        overflow <= 1'b1;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

  assign busy = (state_q == COLLECT);

endmodule
